// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM encoding,
// nibble width and the index-width helper.
package nibble_serial_adder_ctrl_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of an index able to address n items; never narrower than 1 bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int unsigned i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = int'(i) + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla.sv
// 4-bit carry-lookahead adder; carries are computed in parallel from the
// generate/propagate terms rather than rippled.
module cla (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       cin,
   output logic [3:0] S,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   always_comb begin
      g = A & B;
      p = A ^ B;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      S    = p ^ c[3:0];
      cout = c[4];
   end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: latches two W-bit operands, adds one nibble per cycle
// through a single 4-bit CLA, and holds the result until the consumer takes it.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int N_NIB = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIB_W*N_NIB-1:0]   a,
   input  logic [NIB_W*N_NIB-1:0]   b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIB_W*N_NIB-1:0]   sum,
   output logic                     cout,
   output logic                     busy
);

   localparam int W     = NIB_W * N_NIB;
   localparam int IDX_W = clog2(N_NIB);

   state_t             state_q;
   state_t             state_d;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       sum_q;
   logic               carry_q;
   logic               cout_q;
   logic [IDX_W-1:0]   nib_idx;

   logic               accept;
   logic               step;
   logic               last;
   logic [NIB_W-1:0]   nib_a;
   logic [NIB_W-1:0]   nib_b;
   logic [NIB_W-1:0]   nib_s;
   logic               nib_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (nib_idx == IDX_W'(N_NIB - 1)) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Mux the current nibble of each latched operand into the shared CLA.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int unsigned i = 0; i < N_NIB; i++) begin
         if (nib_idx == IDX_W'(i)) begin
            nib_a = a_q[i*NIB_W +: NIB_W];
            nib_b = b_q[i*NIB_W +: NIB_W];
         end
      end
   end

   cla u_cla (
      .A    (nib_a),
      .B    (nib_b),
      .cin  (carry_q),
      .S    (nib_s),
      .cout (nib_c)
   );

   // The carry register is seeded with cin so the first nibble needs no special case.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         nib_idx <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= cin;
         nib_idx <= '0;
      end else if (step) begin
         for (int unsigned i = 0; i < N_NIB; i++) begin
            if (nib_idx == IDX_W'(i)) sum_q[i*NIB_W +: NIB_W] <= nib_s;
         end
         carry_q <= nib_c;
         if (last) begin
            cout_q  <= nib_c;
            nib_idx <= '0;
         end else begin
            nib_idx <= nib_idx + IDX_W'(1);
         end
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed corner cases plus
// random back-to-back operations, checked against a queue of modelled results.
module tb_nibble_serial_adder_ctrl;

   localparam int N_NIB = 4;
   localparam int W     = 4 * N_NIB;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          cin = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  sum;
   logic          cout;
   logic          busy;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   nibble_serial_adder_ctrl #(.N_NIB(N_NIB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c);
      logic [W:0] r;
      exp_t e;
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      e.sum  = r[W-1:0];
      e.cout = r[W];
      return e;
   endfunction

   // Presents one operation and returns just after the accepting edge.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int k;
      k = 0;
      while (!in_ready && k < 40) begin
         tick();
         k++;
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL issue_ready: in_ready=%b required 1 after %0d cycles", in_ready, k);
      end
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = c;
      sb.push_back(model(x, y, c));
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL accept: busy=%b in_ready=%b required busy=1 in_ready=0", busy, in_ready);
      end
   endtask

   task automatic wait_valid(input int exp_edges);
      int k;
      k = 0;
      while (!out_valid && k < 40) begin
         tick();
         k++;
      end
      n_cmp++;
      if (out_valid !== 1'b1 || k != exp_edges) begin
         n_err++;
         $display("FAIL latency: out_valid=%b after %0d edges, required 1 after %0d",
                  out_valid, k, exp_edges);
      end
   endtask

   task automatic compare_and_release(input logic keep_ready);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard: result seen with empty queue, sum=%h cout=%b", sum, cout);
         return;
      end
      e = sb.pop_front();
      n_cmp++;
      if (sum !== e.sum || cout !== e.cout) begin
         n_err++;
         $display("FAIL result: sum=%h cout=%b required sum=%h cout=%b", sum, cout, e.sum, e.cout);
      end
      n_cmp++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL done_flags: in_ready=%b busy=%b required 0/1", in_ready, busy);
      end
      out_ready = 1'b1;
      tick();
      out_ready = keep_ready;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
          sum !== e.sum || cout !== e.cout) begin
         n_err++;
         $display("FAIL release: out_valid=%b in_ready=%b busy=%b sum=%h cout=%b required 0/1/0 %h/%b",
                  out_valid, in_ready, busy, sum, cout, e.sum, e.cout);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_ready = 1'b1;
      #12;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          sum !== '0 || cout !== 1'b0) begin
         n_err++;
         $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b required 1/0/0/0000/0",
                  in_ready, out_valid, busy, sum, cout);
      end
      tick();
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_hold: busy=%b out_valid=%b required 0/0", busy, out_valid);
      end
      out_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_wrap();
      issue(16'hFFFF, 16'h0001, 1'b0);
      wait_valid(N_NIB);
      compare_and_release(1'b0);
   endtask

   task automatic test_carry_in();
      issue(16'h1234, 16'h4321, 1'b1);
      wait_valid(N_NIB);
      compare_and_release(1'b0);
   endtask

   task automatic test_top_nibble();
      issue(16'h8000, 16'h8000, 1'b0);
      wait_valid(N_NIB);
      compare_and_release(1'b0);
      issue(16'h7FFF, 16'h0000, 1'b1);
      wait_valid(N_NIB);
      compare_and_release(1'b0);
   endtask

   task automatic test_backpressure();
      exp_t e;
      issue(16'hA5C3, 16'h3C5A, 1'b1);
      wait_valid(N_NIB);
      e = model(16'hA5C3, 16'h3C5A, 1'b1);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 3 == 0);
         a = 16'(i * 16'h1111);
         b = 16'hFFFF;
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.sum || cout !== e.cout) begin
            n_err++;
            $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b sum=%h cout=%b required 1/0 %h/%b",
                     i, out_valid, in_ready, sum, cout, e.sum, e.cout);
         end
      end
      in_valid = 1'b0;
      compare_and_release(1'b0);
   endtask

   task automatic test_busy_requests();
      issue(16'h1111, 16'h2222, 1'b0);
      tick();
      in_valid = 1'b1;
      a = 16'hABCD;
      b = 16'h5555;
      cin = 1'b1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL run_in_ready: in_ready=%b required 0", in_ready);
      end
      tick();
      in_valid = 1'b0;
      a = 16'hFFFF;
      b = 16'hFFFF;
      wait_valid(N_NIB - 2);
      compare_and_release(1'b0);
   endtask

   task automatic test_reset_mid_run();
      issue(16'h1234, 16'h1111, 1'b0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
          sum !== '0 || cout !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b required 1/0/0/0000/0",
                  in_ready, out_valid, busy, sum, cout);
      end
      #20;
      n_cmp++;
      if (out_valid !== 1'b0 || sum !== '0) begin
         n_err++;
         $display("FAIL reset_no_result: out_valid=%b sum=%h required 0/0000", out_valid, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(16'h00FF, 16'h0001, 1'b0);
      wait_valid(N_NIB);
      compare_and_release(1'b0);
   endtask

   task automatic test_back_to_back();
      exp_t last_e;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] x;
         logic [W-1:0] y;
         logic         c;
         x = W'($urandom);
         y = W'($urandom);
         c = 1'($urandom_range(0, 1));
         last_e = model(x, y, c);
         issue(x, y, c);
         wait_valid(N_NIB);
         compare_and_release(1'b1);
      end
      out_ready = 1'b0;
      repeat (5) tick();
      n_cmp++;
      if (sum !== last_e.sum || cout !== last_e.cout || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL idle_hold: sum=%h cout=%b out_valid=%b required %h/%b/0",
                  sum, cout, out_valid, last_e.sum, last_e.cout);
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_carry_in();
      test_top_nibble();
      test_backpressure();
      test_busy_requests();
      test_reset_mid_run();
      test_back_to_back();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
NIBBLE_SERIAL_ADDER_CTRL -- requirements
Module: nibble_serial_adder_ctrl

Interface
REQ-001 Parameter: N_NIB, 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIB; legal range 2..8.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous and active-low.
REQ-004 Port: in_valid  input  1  requester presents an operation.
REQ-005 Port: in_ready  output  1  block can accept an operation.
REQ-006 Port: a  input  W  operand A.
REQ-007 Port: b  input  W  operand B.
REQ-008 Port: cin  input  1  carry-in for the operation.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: sum  output  W  result sum.
REQ-012 Port: cout  output  1  carry-out of the most significant nibble.
REQ-013 Port: busy  output  1  high in RUN and DONE.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1; on in_valid&in_ready at a rising edge, latch a, b and cin, clear nib_idx to 0, and go to RUN.
REQ-016 RUN: each cycle, add nibble nib_idx of the latched A and B with the carry register through one combinational 4-bit CLA, write its sum into sum[4*nib_idx+:4], load its carry-out into the carry register, and increment nib_idx.
REQ-017 RUN: when the edge processes nib_idx==N_NIB-1, also load cout from the CLA carry-out and go to DONE.
REQ-018 Latency: out_valid SHALL rise exactly N_NIB rising edges after the accepting edge.
REQ-019 DONE: out_valid=1; sum and cout held stable; on out_ready, go to IDLE at that edge.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid in those states is ignored and does not change latched operands.
REQ-021 Minimum issue interval SHALL be N_NIB+2 cycles: accept edge, N_NIB RUN edges, release edge.
REQ-022 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-023 out_ready in IDLE or RUN SHALL have no effect.
REQ-024 Result SHALL equal {cout,sum} = A + B + cin modulo 2^(W+1); wrap-around SHALL be reported only through cout.
REQ-025 sum SHALL keep the previous result in IDLE. It changes only nibble-by-nibble during RUN.

Reset
REQ-026 rst_n low SHALL force IDLE immediately, without waiting for clk, in any state including mid-RUN. An operation in progress is discarded, with no partial result and no out_valid.
REQ-027 Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, nib_idx=0, carry register=0, operand registers=0.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the NIB_W=4 constant, and the nib_idx width function clog2(N_NIB).
REQ-030 Exactly one sub-module SHALL be instantiated: the team's existing cla 4-bit carry-lookahead adder (A, B, cin, S, cout). No other adder logic is allowed.
REQ-031 Operand, sum, carry and nib_idx registers SHALL all be reset asynchronously by rst_n.

Verification
REQ-032 Wrap case: a=0xFFFF, b=0x0001, cin=0 -> out_valid on 4th edge after accept, sum=0x0000, cout=1.
REQ-033 Carry-in case: a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
REQ-034 Top-nibble carry: a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1; a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0.
REQ-035 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, sum and cout stable, in_ready=0. Then out_ready=1 -> IDLE next edge and in_ready=1.
REQ-036 Busy requests: pulse in_valid with new operands during RUN -> ignored; the result matches the first operands.
REQ-037 Reset mid-RUN: assert rst_n low after 2 RUN edges -> outputs reach reset values without clk; after release, a new op 0x00FF+0x0001 gives sum=0x0100, cout=0.
